// File: rtl/data_fifo_pkg.sv
// Shared defaults and sizing helper for the data FIFO and its storage.
package data_fifo_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_AF_THRESH = DEF_DEPTH - 2;

   // Level must represent 0..depth inclusive, hence one bit more than a pointer.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/data_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module data_fifo_mem
   import data_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Asynchronous read keeps the head word visible in the cycle after a write.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_fifo.sv
// First-word-fall-through FIFO with level tracking and sticky overflow/underflow flags.
module data_fifo
   import data_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   err_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] mem_rdata;

   // Acceptance looks only at the registered flags, never at same-cycle traffic.
   assign empty       = (level_q == '0);
   assign full        = (level_q == LVL_W'(DEPTH));
   assign almost_full = (level_q >= LVL_W'(AF_THRESH));
   assign wr_acc      = wr_en && !full && !rst;
   assign rd_acc      = rd_en && !empty && !rst;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      // A new error in the same cycle as err_clr wins.
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
         underflow_d = 1'b1;
      end
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   data_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   assign rd_data   = empty ? '0 : mem_rdata;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_data_fifo.sv
// Scoreboard bench for data_fifo: a queue holds expected words, flags come from a level model.
module tb_data_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int AFT   = DEPTH - 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en = 1'b0;
   logic             err_clr = 1'b0;
   logic             full, almost_full, empty, overflow, underflow;
   logic [WIDTH-1:0] rd_data;
   logic [3:0]       level;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] sb_q[$];
   int               m_level = 0;
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   data_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (almost_full),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .level       (level),
      .overflow    (overflow),
      .underflow   (underflow),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check_val({tag, ".level"}, 64'(level), 64'(m_level));
      check_val({tag, ".empty"}, 64'(empty), 64'(m_level == 0));
      check_val({tag, ".full"}, 64'(full), 64'(m_level == DEPTH));
      check_val({tag, ".afull"}, 64'(almost_full), 64'(m_level >= AFT));
      check_val({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
      check_val({tag, ".unf"}, 64'(underflow), 64'(m_unf));
   endtask

   // One clock with the given stimulus; data is checked before the edge, flags after it.
   task automatic cycle(input string tag, input logic w, input logic [WIDTH-1:0] wd,
                        input logic r, input logic c, input logic rs);
      logic wa, ra;
      wr_en = w; wr_data = wd; rd_en = r; err_clr = c; rst = rs;
      #1;
      wa = w && (m_level != DEPTH) && !rs;
      ra = r && (m_level != 0) && !rs;
      if (m_level == 0) begin
         check_val({tag, ".rd_zero"}, 64'(rd_data), 64'd0);
      end else if (ra) begin
         check_val({tag, ".rd_data"}, 64'(rd_data), 64'(sb_q[0]));
         void'(sb_q.pop_front());
      end
      if (wa) sb_q.push_back(wd);
      if (rs) begin
         m_level = 0; m_ovf = 1'b0; m_unf = 1'b0; sb_q.delete();
      end else begin
         m_ovf   = (m_ovf && !c) || (w && m_level == DEPTH);
         m_unf   = (m_unf && !c) || (r && m_level == 0);
         m_level = m_level + int'(wa) - int'(ra);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
      check_state(tag);
      $display("txn %-6s w=%0b wd=0x%08h r=%0b clr=%0b rst=%0b -> level=%0d rd_data=0x%08h",
               tag, w, wd, r, c, rs, level, rd_data);
   endtask

   initial begin
      // Reset
      cycle("rst", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle("rst", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      check_val("rst.rd_data", 64'(rd_data), 64'd0);

      // Single word, latency 1
      cycle("w1", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      check_val("w1.head", 64'(rd_data), 64'hA5A5_0001);
      cycle("r1", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Fill to full, one dropped write, drain in order
      for (int i = 1; i <= 9; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
      check_val("fill.ovf", 64'(overflow), 64'd1);
      for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Underflow and clear
      cycle("under", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_val("under.flag", 64'(underflow), 64'd1);
      cycle("uclr", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Level 4, simultaneous traffic across pointer wrap
      for (int i = 0; i < 4; i++) cycle("pre4", 1'b1, 32'h100 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("both", 1'b1, 32'h200 + WIDTH'(i), 1'b1, 1'b0, 1'b0);
      check_val("both.level", 64'(level), 64'd4);
      for (int i = 0; i < 4; i++) cycle("post4", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Full with read and write together
      for (int i = 0; i < 8; i++) cycle("f8", 1'b1, 32'h300 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
      cycle("fboth", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      check_val("fboth.level", 64'(level), 64'd7);
      for (int i = 0; i < 7; i++) cycle("fdrain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("fclr", 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Reset mid-burst with a write presented
      for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 32'h400 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
      cycle("midrst", 1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b1);
      check_val("midrst.level", 64'(level), 64'd0);
      cycle("after", 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
      cycle("afterr", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cycle("rnd", 1'($urandom_range(0, 1)), WIDTH'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 63) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_fifo.md
DATA_FIFO -- requirements
Module: data_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning entry count; legal values are powers of 2, minimum 2.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, meaning the level at which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  WIDTH  write word.
REQ-008 full  output  1  no free entry.
REQ-009 almost_full  output  1  level >= AF_THRESH.
REQ-010 rd_en  input  1  pop request; driven by the downstream FSM's read_en.
REQ-011 rd_data  output  WIDTH  head word, first-word-fall-through.
REQ-012 empty  output  1  no stored entry.
REQ-013 level  output  log2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-014 overflow  output  1  sticky: write attempted while full.
REQ-015 underflow  output  1  sticky: read attempted while empty.
REQ-016 err_clr  input  1  clears overflow and underflow.

Function
REQ-017 A write SHALL be accepted iff wr_en=1 and full=0; the word is stored at the write pointer, which then increments.
REQ-018 A read SHALL be accepted iff rd_en=1 and empty=0; the read pointer then increments.
REQ-019 Acceptance SHALL use registered full/empty only: wr_en while full is dropped even if a read is accepted in the same cycle; rd_en while empty is rejected even if a write is accepted in the same cycle.
REQ-020 level SHALL become level+1 on write-only, level-1 on read-only, and stay unchanged on simultaneous accepted read and write or when nothing is accepted.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-022 empty SHALL equal (level==0), full SHALL equal (level==DEPTH), almost_full SHALL equal (level>=AF_THRESH), all derived from the level register.
REQ-023 rd_data SHALL combinationally present the entry at the read pointer when empty=0, and SHALL be all-zero when empty=1.
REQ-024 A word written into an empty FIFO SHALL appear on rd_data, with empty=0, in the cycle after the write edge (latency 1).
REQ-025 overflow SHALL set on the edge following a rejected write; underflow SHALL set on the edge following a rejected read.
REQ-026 Overflow and underflow SHALL hold until err_clr=1 or rst=1; if err_clr and a new error occur in the same cycle, the flag SHALL be set.
REQ-027 Rejected accesses SHALL NOT modify storage, pointers or level.

Reset
REQ-028 When rst=1 at a clock edge, pointers, level, overflow and underflow SHALL be 0; empty=1, full=0, almost_full=0 and rd_data=0 SHALL follow from the cleared level.
REQ-029 Reset SHALL take priority over all concurrent wr_en/rd_en; contents in flight mid-operation are discarded and storage is not cleared.
REQ-030 While rst=1, no write or read SHALL be accepted and no error flag SHALL set.

Structure
REQ-031 Package data_fifo_pkg SHALL hold default WIDTH, DEPTH and AF_THRESH constants and the level-width function.
REQ-032 Storage SHALL be a sub-module data_fifo_mem (one write port, one asynchronous read port, no reset); pointer/level/flag control stays in data_fifo.

Verification
REQ-033 Reset, then write 0xA5A5_0001 -> next cycle empty=0, level=1, rd_data=0xA5A5_0001.
REQ-034 Write 8 words 0x1..0x8 without reads -> full=1 after the 8th write, almost_full=1 from level 6, 9th write dropped, overflow=1, then 8 reads return 0x1..0x8 in order.
REQ-035 rd_en=1 on empty FIFO -> underflow=1, level stays 0, rd_data=0; err_clr=1 for one cycle -> underflow=0.
REQ-036 Level 4, simultaneous wr_en and rd_en for 20 cycles -> level stays 4, output order matches input order across pointer wrap.
REQ-037 Full FIFO, wr_en and rd_en together -> read accepted, write dropped, overflow=1, level=7.
REQ-038 Level 5, rst=1 for one cycle mid-burst -> level=0, empty=1, flags=0; the write presented with rst=1 is not stored.
